// File: rtl/argmax_classifier_if.sv
// Bundles the probability-vector input and the classification result
// of the argmax stage. The upstream/control side uses the master modport and
// the classifier uses the slave modport.
interface argmax_classifier_if #(
  parameter int NUM_CLASSES = 128,
  parameter int ACTIV_BITS  = 8,
  parameter int IDX_BITS    = $clog2(NUM_CLASSES)
);
  logic [NUM_CLASSES*ACTIV_BITS-1:0] data_in;
  logic                              data_valid;
  logic                              busy;
  logic [IDX_BITS-1:0]               class_idx;
  logic [ACTIV_BITS-1:0]             class_score;
  logic                              class_confident;
  logic                              result_valid;
  logic                              drop_err;

  modport master (
    output data_in, data_valid,
    input  busy, class_idx, class_score, class_confident, result_valid, drop_err
  );

  modport slave (
    input  data_in, data_valid,
    output busy, class_idx, class_score, class_confident, result_valid, drop_err
  );
endinterface

// File: rtl/argmax_classifier.sv
// Serial argmax over a packed probability vector.
// The vector is captured once and then scanned one element per cycle.
// A one-cycle result pulse carries the winning index, its score and a
// confidence flag.
//
//   state | meaning
//   IDLE  | waiting for a vector; the only state in which one is accepted
//   SCAN  | comparing element[cnt] against the running max
//   DONE  | result_valid cycle; incoming vectors are dropped
module argmax_classifier #(
  parameter int                    NUM_CLASSES    = 128,
  parameter int                    ACTIV_BITS     = 8,
  parameter logic [ACTIV_BITS-1:0] CONF_THRESHOLD = 8'd128,
  parameter int                    IDX_BITS       = $clog2(NUM_CLASSES)
) (
  input logic                clk,
  input logic                rst,
  argmax_classifier_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_busy;
  logic                  w_result_valid;
  logic                  w_capture;

  logic [ACTIV_BITS-1:0] r_vec [NUM_CLASSES];
  logic [ACTIV_BITS-1:0] r_max;
  logic [IDX_BITS-1:0]   r_idx;
  logic [IDX_BITS-1:0]   r_cnt;
  logic [IDX_BITS-1:0]   r_class_idx;
  logic [ACTIV_BITS-1:0] r_class_score;
  logic                  r_class_confident;
  logic                  r_drop_err;

  logic [ACTIV_BITS-1:0] w_elem;
  logic                  w_greater;
  logic [ACTIV_BITS-1:0] w_new_max;
  logic [IDX_BITS-1:0]   w_new_idx;
  logic                  w_last;

  // Strict greater-than keeps the lower index on ties.
  assign w_elem    = r_vec[r_cnt];
  assign w_greater = (w_elem > r_max);
  assign w_new_max = w_greater ? w_elem : r_max;
  assign w_new_idx = w_greater ? r_cnt : r_idx;
  assign w_last    = (r_cnt == IDX_BITS'(NUM_CLASSES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and status decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_busy         = 1'b0;
    w_result_valid = 1'b0;
    w_capture      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.data_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        w_busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_busy         = 1'b1;
        w_result_valid = 1'b1;
        w_state_nxt    = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the vector, track the running max and publish the final result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CLASSES; k++) r_vec[k] <= '0;
      r_max             <= '0;
      r_idx             <= '0;
      r_cnt             <= '0;
      r_class_idx       <= '0;
      r_class_score     <= '0;
      r_class_confident <= 1'b0;
    end else if (w_capture) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        r_vec[k] <= bus.data_in[k*ACTIV_BITS +: ACTIV_BITS];
      end
      r_max <= bus.data_in[ACTIV_BITS-1:0];
      r_idx <= '0;
      r_cnt <= IDX_BITS'(1);
    end else if (r_state == SCAN) begin
      r_max <= w_new_max;
      r_idx <= w_new_idx;
      if (w_last) begin
        r_class_idx       <= w_new_idx;
        r_class_score     <= w_new_max;
        r_class_confident <= (w_new_max >= CONF_THRESHOLD);
      end else begin
        r_cnt <= r_cnt + IDX_BITS'(1);
      end
    end
  end

  // Sticky flag for vectors offered while a scan is in flight.
  always_ff @(posedge clk) begin
    if (rst)                          r_drop_err <= 1'b0;
    else if (bus.data_valid && w_busy) r_drop_err <= 1'b1;
  end

  assign bus.busy            = w_busy;
  assign bus.result_valid    = w_result_valid;
  assign bus.class_idx       = r_class_idx;
  assign bus.class_score     = r_class_score;
  assign bus.class_confident = r_class_confident;
  assign bus.drop_err        = r_drop_err;

endmodule

// File: tb/tb_argmax_classifier.sv
// Bench for argmax_classifier: a 4-class instance for the detailed scenarios
// and a default 128-class instance for full-length scans.
module tb_argmax_classifier;

  logic clk = 1'b0;
  logic rst4;
  logic rst128;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  argmax_classifier_if #(.NUM_CLASSES(4), .ACTIV_BITS(8)) if4 ();
  argmax_classifier_if #(.NUM_CLASSES(128), .ACTIV_BITS(8)) if128 ();

  argmax_classifier #(.NUM_CLASSES(4), .ACTIV_BITS(8), .CONF_THRESHOLD(8'd128)) u_dut4 (
    .clk(clk), .rst(rst4), .bus(if4)
  );

  argmax_classifier #(.NUM_CLASSES(128), .ACTIV_BITS(8), .CONF_THRESHOLD(8'd128)) u_dut128 (
    .clk(clk), .rst(rst128), .bus(if128)
  );

  // Reference: plain linear search, first occurrence of the maximum wins.
  function automatic void ref_argmax(input int vals[$], output int bi, output int bs);
    bi = 0;
    bs = vals[0];
    foreach (vals[i]) if (vals[i] > bs) begin bs = vals[i]; bi = i; end
  endfunction

  function automatic void unpack4(input logic [31:0] v, output int vals[$]);
    vals = {};
    for (int k = 0; k < 4; k++) vals.push_back(int'(v[k*8 +: 8]));
  endfunction

  // Offers one vector to the 4-class DUT and waits (bounded) for its result.
  task automatic run_vec4(input logic [31:0] vec, input bit scramble,
                          output int lat, output logic busy_after,
                          output logic [1:0] mid_idx, output logic [1:0] idx,
                          output logic [7:0] score, output logic conf);
    lat = -1; idx = 'x; score = 'x; conf = 1'bx; mid_idx = 'x;
    @(posedge clk); #1;
    if4.data_in = vec; if4.data_valid = 1'b1;
    @(posedge clk); #1;
    if4.data_valid = 1'b0;
    busy_after = if4.busy;
    if (scramble) if4.data_in = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) mid_idx = if4.class_idx;
      if (if4.result_valid) begin
        lat = c; idx = if4.class_idx; score = if4.class_score; conf = if4.class_confident;
        break;
      end
    end
  endtask

  task automatic run_vec128(input logic [1023:0] vec, output int lat,
                            output logic [6:0] idx, output logic [7:0] score,
                            output logic conf);
    lat = -1; idx = 'x; score = 'x; conf = 1'bx;
    @(posedge clk); #1;
    if128.data_in = vec; if128.data_valid = 1'b1;
    @(posedge clk); #1;
    if128.data_valid = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (if128.result_valid) begin
        lat = c; idx = if128.class_idx; score = if128.class_score; conf = if128.class_confident;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst4 = 1'b1; rst128 = 1'b1;
    if4.data_valid = 1'b0; if4.data_in = '0;
    if128.data_valid = 1'b0; if128.data_in = '0;
    repeat (3) @(posedge clk);
    #1; rst4 = 1'b0; rst128 = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (if4.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", if4.busy); end
    n_cmp++; if (if4.result_valid !== 1'b0) begin n_err++; $display("FAIL reset_rv got %b want 0", if4.result_valid); end
    n_cmp++; if (if4.drop_err !== 1'b0) begin n_err++; $display("FAIL reset_drop got %b want 0", if4.drop_err); end
    n_cmp++; if (if4.class_idx !== 2'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", if4.class_idx); end
    n_cmp++; if (if4.class_score !== 8'd0) begin n_err++; $display("FAIL reset_score got %0d want 0", if4.class_score); end
    n_cmp++; if (if4.class_confident !== 1'b0) begin n_err++; $display("FAIL reset_conf got %b want 0", if4.class_confident); end
    n_cmp++; if (if128.busy !== 1'b0) begin n_err++; $display("FAIL reset128_busy got %b want 0", if128.busy); end
  endtask

  task automatic test_basic();
    int lat; logic b; logic [1:0] mi, idx; logic [7:0] sc; logic cf;
    run_vec4({8'd30, 8'd50, 8'd200, 8'd10}, 1'b0, lat, b, mi, idx, sc, cf);
    n_cmp++; if (b !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b want 1", b); end
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL basic_latency got %0d want 3", lat); end
    n_cmp++; if (idx !== 2'd1) begin n_err++; $display("FAIL basic_idx got %0d want 1", idx); end
    n_cmp++; if (sc !== 8'd200) begin n_err++; $display("FAIL basic_score got %0d want 200", sc); end
    n_cmp++; if (cf !== 1'b1) begin n_err++; $display("FAIL basic_conf got %b want 1", cf); end
    @(posedge clk); #1;
    n_cmp++; if (if4.result_valid !== 1'b0) begin n_err++; $display("FAIL basic_pulse_width got %b want 0", if4.result_valid); end
    n_cmp++; if (if4.busy !== 1'b0) begin n_err++; $display("FAIL basic_idle got %b want 0", if4.busy); end
    n_cmp++; if (if4.class_idx !== 2'd1) begin n_err++; $display("FAIL basic_hold got %0d want 1", if4.class_idx); end
  endtask

  task automatic test_last_slot();
    int lat; logic b; logic [1:0] mi, idx; logic [7:0] sc; logic cf;
    run_vec4({8'd255, 8'd3, 8'd2, 8'd1}, 1'b1, lat, b, mi, idx, sc, cf);
    n_cmp++; if (mi !== 2'd1) begin n_err++; $display("FAIL last_hold_mid got %0d want 1", mi); end
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL last_latency got %0d want 3", lat); end
    n_cmp++; if (idx !== 2'd3) begin n_err++; $display("FAIL last_idx got %0d want 3", idx); end
    n_cmp++; if (sc !== 8'd255) begin n_err++; $display("FAIL last_score got %0d want 255", sc); end
  endtask

  task automatic test_tie();
    int lat; logic b; logic [1:0] mi, idx; logic [7:0] sc; logic cf;
    run_vec4({8'd90, 8'd20, 8'd90, 8'd90}, 1'b0, lat, b, mi, idx, sc, cf);
    n_cmp++; if (idx !== 2'd0) begin n_err++; $display("FAIL tie_idx got %0d want 0", idx); end
    n_cmp++; if (sc !== 8'd90) begin n_err++; $display("FAIL tie_score got %0d want 90", sc); end
    n_cmp++; if (cf !== 1'b0) begin n_err++; $display("FAIL tie_conf got %b want 0", cf); end
  endtask

  task automatic test_drop();
    int pulses; logic [1:0] idx; logic [7:0] sc; bit seen;
    @(posedge clk); #1;
    if4.data_in = {8'd4, 8'd180, 8'd6, 8'd5}; if4.data_valid = 1'b1;
    @(posedge clk); #1;
    if4.data_valid = 1'b0;
    @(posedge clk); #1;
    if4.data_in = {8'd0, 8'd0, 8'd0, 8'd255}; if4.data_valid = 1'b1;
    @(posedge clk); #1;
    if4.data_valid = 1'b0;
    n_cmp++; if (if4.drop_err !== 1'b1) begin n_err++; $display("FAIL drop_flag got %b want 1", if4.drop_err); end
    seen = 1'b0; idx = 'x; sc = 'x;
    for (int c = 0; c < 10; c++) begin
      if (if4.result_valid) begin seen = 1'b1; idx = if4.class_idx; sc = if4.class_score; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (idx !== 2'd2) begin n_err++; $display("FAIL drop_inflight_idx got %0d want 2", idx); end
    n_cmp++; if (sc !== 8'd180) begin n_err++; $display("FAIL drop_inflight_score got %0d want 180", sc); end
    // First IDLE cycle after DONE: offer the next vector immediately.
    @(posedge clk); #1;
    if4.data_in = {8'd9, 8'd8, 8'd77, 8'd7}; if4.data_valid = 1'b1;
    @(posedge clk); #1;
    if4.data_valid = 1'b0;
    n_cmp++; if (if4.busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got %b want 1", if4.busy); end
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (if4.result_valid) begin pulses++; idx = if4.class_idx; sc = if4.class_score; end
    end
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL b2b_pulses got %0d want 1", pulses); end
    n_cmp++; if (idx !== 2'd1) begin n_err++; $display("FAIL b2b_idx got %0d want 1", idx); end
    n_cmp++; if (sc !== 8'd77) begin n_err++; $display("FAIL b2b_score got %0d want 77", sc); end
    n_cmp++; if (if4.drop_err !== 1'b1) begin n_err++; $display("FAIL drop_sticky got %b want 1", if4.drop_err); end
  endtask

  task automatic test_mid_rst();
    int lat, pulses; logic b; logic [1:0] mi, idx; logic [7:0] sc; logic cf;
    @(posedge clk); #1;
    if4.data_in = {8'd1, 8'd2, 8'd250, 8'd3}; if4.data_valid = 1'b1;
    @(posedge clk); #1;
    if4.data_valid = 1'b0;
    @(posedge clk); #1;
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    n_cmp++; if (if4.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", if4.busy); end
    n_cmp++; if (if4.drop_err !== 1'b0) begin n_err++; $display("FAIL rst_drop got %b want 0", if4.drop_err); end
    n_cmp++; if (if4.class_idx !== 2'd0) begin n_err++; $display("FAIL rst_idx got %0d want 0", if4.class_idx); end
    n_cmp++; if (if4.class_score !== 8'd0) begin n_err++; $display("FAIL rst_score got %0d want 0", if4.class_score); end
    n_cmp++; if (if4.class_confident !== 1'b0) begin n_err++; $display("FAIL rst_conf got %b want 0", if4.class_confident); end
    rst4 = 1'b1; if4.data_valid = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0; if4.data_valid = 1'b0;
    n_cmp++; if (if4.busy !== 1'b0) begin n_err++; $display("FAIL rst_wins got %b want 0", if4.busy); end
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (if4.result_valid) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL rst_no_pulse got %0d want 0", pulses); end
    run_vec4({8'd7, 8'd0, 8'd0, 8'd0}, 1'b0, lat, b, mi, idx, sc, cf);
    n_cmp++; if (idx !== 2'd3) begin n_err++; $display("FAIL after_rst_idx got %0d want 3", idx); end
    n_cmp++; if (sc !== 8'd7) begin n_err++; $display("FAIL after_rst_score got %0d want 7", sc); end
  endtask

  task automatic test_random4();
    int lat, bi, bs; int vals[$]; logic b; logic [1:0] mi, idx; logic [7:0] sc; logic cf;
    logic [31:0] v;
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'($urandom_range(0, 7) * 36);
      unpack4(v, vals);
      ref_argmax(vals, bi, bs);
      run_vec4(v, ($urandom_range(0, 1) == 1), lat, b, mi, idx, sc, cf);
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rand4_latency vec %h got %0d want 3", v, lat); end
      n_cmp++; if (idx !== 2'(bi)) begin n_err++; $display("FAIL rand4_idx vec %h got %0d want %0d", v, idx, bi); end
      n_cmp++; if (sc !== 8'(bs)) begin n_err++; $display("FAIL rand4_score vec %h got %0d want %0d", v, sc, bs); end
      n_cmp++; if (cf !== (bs >= 128)) begin n_err++; $display("FAIL rand4_conf vec %h got %b want %b", v, cf, bs >= 128); end
    end
  endtask

  task automatic test_full128();
    int lat, bi, bs; int vals[$]; logic [6:0] idx; logic [7:0] sc; logic cf;
    logic [1023:0] v;
    for (int k = 0; k < 128; k++) v[k*8 +: 8] = 8'(k);
    v[77*8 +: 8] = 8'd255;
    run_vec128(v, lat, idx, sc, cf);
    n_cmp++; if (lat !== 127) begin n_err++; $display("FAIL full128_latency got %0d want 127", lat); end
    n_cmp++; if (idx !== 7'd77) begin n_err++; $display("FAIL full128_idx got %0d want 77", idx); end
    n_cmp++; if (sc !== 8'd255) begin n_err++; $display("FAIL full128_score got %0d want 255", sc); end
    n_cmp++; if (cf !== 1'b1) begin n_err++; $display("FAIL full128_conf got %b want 1", cf); end
    for (int n = 0; n < 4; n++) begin
      vals = {};
      for (int k = 0; k < 128; k++) begin
        v[k*8 +: 8] = 8'($urandom_range(0, 120));
        vals.push_back(int'(v[k*8 +: 8]));
      end
      ref_argmax(vals, bi, bs);
      run_vec128(v, lat, idx, sc, cf);
      n_cmp++; if (idx !== 7'(bi)) begin n_err++; $display("FAIL rand128_idx got %0d want %0d", idx, bi); end
      n_cmp++; if (sc !== 8'(bs)) begin n_err++; $display("FAIL rand128_score got %0d want %0d", sc, bs); end
      n_cmp++; if (cf !== 1'b0) begin n_err++; $display("FAIL rand128_conf got %b want 0", cf); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_last_slot();
    test_tie();
    test_drop();
    test_mid_rst();
    test_random4();
    test_full128();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Final decision stage directly downstream of the softmax block.
- Consumes the packed probability vector (data_out/data_out_valid of softmax). Scans it serially, one element per cycle, to find the winning class index and its score.
- Flags whether the winner meets a confidence threshold. Produces a one-cycle result pulse for the keyword-spotting control logic.

Parameters:
- NUM_CLASSES, 128, number of packed input elements; must be >= 2.
- ACTIV_BITS, 8, width of each unsigned element.
- CONF_THRESHOLD, 8'd128, unsigned threshold for class_confident (ACTIV_BITS wide).
- IDX_BITS, $clog2(NUM_CLASSES), width of index outputs.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  NUM_CLASSES*ACTIV_BITS  packed vector; element k = data_in[k*ACTIV_BITS +: ACTIV_BITS].
- data_valid  input  1  vector present this cycle.
- busy  output  1  high while a vector is being processed; new vectors are accepted only when low.
- class_idx  output  IDX_BITS  index of the maximum element.
- class_score  output  ACTIV_BITS  value of the maximum element.
- class_confident  output  1  class_score >= CONF_THRESHOLD.
- result_valid  output  1  one-cycle pulse when the outputs above update.
- drop_err  output  1  sticky: data_valid arrived while busy.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); all state is sampled on the rising edge of clk.
- Reset values:
  - state=IDLE, busy=0, result_valid=0, drop_err=0.
  - class_idx=0, class_score=0, class_confident=0.
  - Internal vector register, running max, running index and counter = 0.
- States IDLE, SCAN, DONE; busy = (state != IDLE).
- IDLE:
  - On data_valid=1, capture the full data_in into the internal vector register.
  - Set run_max=element0, run_idx=0, cnt=1, go to SCAN.
  - data_valid=0: stay in IDLE.
- SCAN, each cycle:
  - Compare element[cnt] against run_max.
  - If strictly greater, set run_max=element[cnt] and run_idx=cnt.
  - Ties keep the lower index.
  - If cnt==NUM_CLASSES-1: register the final results into class_idx, class_score and class_confident (computed from the final max, including this cycle's element), set result_valid=1, go to DONE.
  - Otherwise cnt=cnt+1.
- DONE: result_valid=0 next edge, go to IDLE. data_valid here is not accepted.
- Latency:
  - Capture edge E0; result_valid is high in the cycle following edge E0+(NUM_CLASSES-1).
  - Next vector is accepted at the earliest NUM_CLASSES+1 edges after E0.
  - Throughput: one vector per NUM_CLASSES+1 cycles.
- data_valid while busy=1 (SCAN or DONE):
  - The vector is dropped and drop_err is set to 1.
  - drop_err clears only on rst.
  - The in-flight scan is unaffected.
- Outputs class_idx, class_score and class_confident hold their last values until the next result; they never change outside the result_valid cycle.
- Comparisons are unsigned, ACTIV_BITS wide. The counter is IDX_BITS wide and never wraps past NUM_CLASSES-1.
- rst asserted mid-scan:
  - Abort the scan and return all outputs to reset values on that edge.
  - No result_valid pulse for the aborted vector.
- rst and data_valid in the same cycle: rst wins, the vector is not captured.
- Changes on data_in after the capture edge do not affect the result.

Test Plan:
- NUM_CLASSES=4, ACTIV_BITS=8, vector {e0=10,e1=200,e2=50,e3=30}, data_valid one cycle -> busy high next cycle; after 3 more edges result_valid=1 for one cycle with class_idx=1, class_score=200, class_confident=1.
- Tie: {e0=90,e1=90,e2=20,e3=90}, CONF_THRESHOLD=128 -> class_idx=0, class_score=90, class_confident=0.
- Max in last slot {1,2,3,255} -> class_idx=3, class_score=255; data_in changed to all zeros during SCAN does not alter the result.
- Second data_valid two cycles after the first -> dropped, drop_err=1 and stays 1; only one result_valid pulse. A vector at the first IDLE cycle after DONE is accepted normally.
- rst asserted mid-SCAN -> next edge state IDLE, all outputs 0, no result_valid. A subsequent vector {0,0,0,7} gives class_idx=3, class_score=7.
- Default NUM_CLASSES=128, element k=k except element 77=255 -> result_valid exactly 127 edges after capture edge, class_idx=77, class_score=255, class_confident=1.
